program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/program_loader.sv | 109 ++++++++++
 tb/tb_program_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared MIPS loader definitions: halt marker, program-memory depth and the
// loader state encoding, used by the loader and the core it feeds.
package program_loader_pkg;

  // Instruction word that ends a program download.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Number of instruction words the program memory can hold.
  localparam int PM_DEPTH = 32;

  // Width of the word counter; it must be able to represent PM_DEPTH itself.
  localparam int WORD_COUNT_W = 6;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } loader_state_e;

  // Append one received byte to the word under assembly. The first byte of a
  // word ends up in [31:24] after four shifts.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  data);
    return {word[23:0], data};
  endfunction

endpackage

// File: rtl/program_loader.sv
// Program loader: assembles bytes from a serial receiver into 32-bit
// instruction words, writes them into the MIPS program memory, and holds the
// CPU in reset until the program has been fully loaded.
module program_loader
  import program_loader_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    I_RX_VALID,
  input  logic [7:0]              I_RX_DATA,
  input  logic                    I_RELOAD,
  output logic                    O_WR_PM,
  output logic [31:0]             O_WR_DATA_PM,
  output logic [WORD_COUNT_W-1:0] O_WORD_COUNT,
  output logic                    O_CPU_RESET,
  output logic                    O_DONE,
  output logic                    O_OVERFLOW
);

  loader_state_e           state;
  logic [1:0]              byte_cnt;
  logic [31:0]             asm_word;

  logic [31:0]             asm_next;
  logic [WORD_COUNT_W-1:0] count_next;
  logic                    hit_halt;
  logic                    hit_depth;

  // Next-value helpers shared by the LOAD and WRITE branches of the FSM.
  // NOTE: every output of a combinational block gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    asm_next   = shift_in_byte(asm_word, I_RX_DATA);
    count_next = O_WORD_COUNT + WORD_COUNT_W'(1);
    hit_halt   = (O_WR_DATA_PM == HALT_WORD);
    hit_depth  = (count_next == WORD_COUNT_W'(PM_DEPTH));
  end

  // Loader FSM with inline byte assembler; every output is registered.
  // NOTE: state is updated with non-blocking assignments so all registers
  // see the values from before the clock edge, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_LOAD;
      byte_cnt     <= 2'd0;
      asm_word     <= 32'd0;
      O_WR_PM      <= 1'b0;
      O_WR_DATA_PM <= 32'd0;
      O_WORD_COUNT <= '0;
      O_CPU_RESET  <= 1'b1;
      O_DONE       <= 1'b0;
      O_OVERFLOW   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (I_RX_VALID) begin
            asm_word <= asm_next;
            byte_cnt <= byte_cnt + 2'd1;
            // Fourth byte completes the word: publish it and strobe the write.
            if (byte_cnt == 2'd3) begin
              O_WR_DATA_PM <= asm_next;
              O_WR_PM      <= 1'b1;
              state        <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          // The write strobe lasts exactly this one cycle.
          O_WR_PM      <= 1'b0;
          O_WORD_COUNT <= count_next;
          // A new word cannot complete within one cycle of the last one, so a
          // byte here is only ever the first byte of the following word.
          if (I_RX_VALID) begin
            asm_word <= asm_next;
            byte_cnt <= byte_cnt + 2'd1;
          end
          if (hit_halt || hit_depth) begin
            state       <= ST_DONE;
            O_DONE      <= 1'b1;
            O_CPU_RESET <= 1'b0;
            // A halt word on the last slot is a normal end, not an overflow.
            O_OVERFLOW  <= !hit_halt;
          end else begin
            state <= ST_LOAD;
          end
        end

        ST_DONE: begin
          // Received bytes are ignored here; only a reload restarts loading.
          if (I_RELOAD) begin
            state        <= ST_LOAD;
            byte_cnt     <= 2'd0;
            asm_word     <= 32'd0;
            O_WORD_COUNT <= '0;
            O_OVERFLOW   <= 1'b0;
            O_CPU_RESET  <= 1'b1;
            O_DONE       <= 1'b0;
          end
        end

        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven word sequence,
// hand-written reset/reload/back-to-back corner cases, randomized byte
// streams against a word-list model, and the 32-word overflow case.
`timescale 1ns/1ps
module tb_program_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        CLK;
  logic        RESET;
  logic        I_RX_VALID;
  logic [7:0]  I_RX_DATA;
  logic        I_RELOAD;
  logic        O_WR_PM;
  logic [31:0] O_WR_DATA_PM;
  logic [5:0]  O_WORD_COUNT;
  logic        O_CPU_RESET;
  logic        O_DONE;
  logic        O_OVERFLOW;

  int total = 0;
  int bad   = 0;

  // Pulses seen by the monitor, and the data carried by each.
  int          pulses = 0;
  logic [31:0] got_q[$];
  logic        prev_pm = 1'b0;

  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] exp_data;
    logic [5:0]  exp_count;
    logic        exp_done;
  } vec_t;

  vec_t vecs[3];

  program_loader dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .I_RX_VALID   (I_RX_VALID),
    .I_RX_DATA    (I_RX_DATA),
    .I_RELOAD     (I_RELOAD),
    .O_WR_PM      (O_WR_PM),
    .O_WR_DATA_PM (O_WR_DATA_PM),
    .O_WORD_COUNT (O_WORD_COUNT),
    .O_CPU_RESET  (O_CPU_RESET),
    .O_DONE       (O_DONE),
    .O_OVERFLOW   (O_OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor on the falling edge: records every write pulse and checks width.
  initial begin
    forever begin
      @(negedge CLK);
      if (prev_pm) check("pm_one_cycle", {31'd0, O_WR_PM}, 32'd0);
      prev_pm = O_WR_PM;
      if (O_WR_PM) begin
        pulses++;
        got_q.push_back(O_WR_DATA_PM);
      end
    end
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    I_RX_VALID = 1'b1;
    I_RX_DATA  = b;
    tick();
    I_RX_VALID = 1'b0;
    I_RX_DATA  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) tick();
      send_byte(w[31 - 8*i -: 8]);
    end
  endtask

  // Returns with the pulse cycle current, or ok=0 after a bounded wait.
  task automatic wait_pulse(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (O_WR_PM) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic        ok;
    int          p0;
    logic [31:0] words[10];
    logic [31:0] exp_q[$];
    logic        halted;
    logic [31:0] w;

    RESET      = 1'b1;
    I_RX_VALID = 1'b0;
    I_RX_DATA  = 8'h00;
    I_RELOAD   = 1'b0;

    vecs[0] = '{32'h2001_0005, 32'h2001_0005, 6'd1, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 6'd2, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 1'b1};

    // ---------------- reset state ----------------
    #12;
    check("rst_wr_pm",    {31'd0, O_WR_PM},     32'd0);
    check("rst_wr_data",  O_WR_DATA_PM,         32'd0);
    check("rst_count",    {26'd0, O_WORD_COUNT}, 32'd0);
    check("rst_cpu_rst",  {31'd0, O_CPU_RESET}, 32'd1);
    check("rst_done",     {31'd0, O_DONE},      32'd0);
    check("rst_overflow", {31'd0, O_OVERFLOW},  32'd0);
    RESET = 1'b0;
    tick();

    // ---------------- table: two words then halt ----------------
    for (int i = 0; i < 3; i++) begin
      send_word(vecs[i].bytes, 2);
      wait_pulse(ok);
      check("tbl_pulse_seen", {31'd0, ok}, 32'd1);
      check("tbl_data", O_WR_DATA_PM, vecs[i].exp_data);
      check("tbl_cpu_rst_in_write", {31'd0, O_CPU_RESET}, 32'd1);
      tick();
      check("tbl_count", {26'd0, O_WORD_COUNT}, {26'd0, vecs[i].exp_count});
      check("tbl_done", {31'd0, O_DONE}, {31'd0, vecs[i].exp_done});
      check("tbl_cpu_rst_after", {31'd0, O_CPU_RESET}, {31'd0, !vecs[i].exp_done});
      check("tbl_overflow", {31'd0, O_OVERFLOW}, 32'd0);
      check("tbl_data_hold", O_WR_DATA_PM, vecs[i].exp_data);
    end

    // ---------------- bytes in DONE are ignored ----------------
    p0 = pulses;
    send_word(32'h1111_2222, 0);
    send_word(32'h3333_4444, 1);
    tick();
    tick();
    check("done_no_pulse", pulses, p0);
    check("done_count_hold", {26'd0, O_WORD_COUNT}, 32'd3);
    check("done_still_done", {31'd0, O_DONE}, 32'd1);

    // ---------------- reload from DONE ----------------
    I_RELOAD = 1'b1;
    tick();
    check("reload_count", {26'd0, O_WORD_COUNT}, 32'd0);
    check("reload_overflow", {31'd0, O_OVERFLOW}, 32'd0);
    check("reload_cpu_rst", {31'd0, O_CPU_RESET}, 32'd1);
    check("reload_done", {31'd0, O_DONE}, 32'd0);
    // Reload held high outside DONE has no effect on loading.
    send_word(32'h0BAD_F00D, 1);
    wait_pulse(ok);
    check("reload_pulse_seen", {31'd0, ok}, 32'd1);
    check("reload_data", O_WR_DATA_PM, 32'h0BAD_F00D);
    tick();
    I_RELOAD = 1'b0;
    check("reload_count1", {26'd0, O_WORD_COUNT}, 32'd1);

    // ---------------- back-to-back words (byte during WRITE) ----------------
    do_reset();
    got_q.delete();
    send_word(32'h0102_0304, 0);
    send_word(32'hA5B6_C7D8, 0);
    tick();
    tick();
    check("b2b_pulses", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("b2b_word0", got_q[0], 32'h0102_0304);
      check("b2b_word1", got_q[1], 32'hA5B6_C7D8);
    end
    check("b2b_count", {26'd0, O_WORD_COUNT}, 32'd2);

    // ---------------- reset with a partial word ----------------
    send_byte(8'hAA);
    send_byte(8'hBB);
    RESET = 1'b1;
    #2;
    check("part_rst_count", {26'd0, O_WORD_COUNT}, 32'd0);
    check("part_rst_data", O_WR_DATA_PM, 32'd0);
    RESET = 1'b0;
    tick();
    got_q.delete();
    send_word(32'h1234_5678, 1);
    wait_pulse(ok);
    check("part_pulse_seen", {31'd0, ok}, 32'd1);
    check("part_data", O_WR_DATA_PM, 32'h1234_5678);
    tick();
    check("part_count", {26'd0, O_WORD_COUNT}, 32'd1);
    check("part_single_pulse", got_q.size(), 32'd1);

    // ---------------- reset during WRITE aborts the strobe ----------------
    send_word(32'hCAFE_0001, 0);
    check("wr_rst_pm_before", {31'd0, O_WR_PM}, 32'd1);
    RESET = 1'b1;
    #1;
    check("wr_rst_pm_abort", {31'd0, O_WR_PM}, 32'd0);
    check("wr_rst_count", {26'd0, O_WORD_COUNT}, 32'd0);
    #2;
    RESET = 1'b0;
    tick();
    check("wr_rst_count_after", {26'd0, O_WORD_COUNT}, 32'd0);
    check("wr_rst_cpu_rst", {31'd0, O_CPU_RESET}, 32'd1);

    // ---------------- randomized streams against the word-list model ----------------
    for (int r = 0; r < 4; r++) begin
      do_reset();
      got_q.delete();
      exp_q.delete();
      halted = 1'b0;
      for (int i = 0; i < 10; i++) begin
        words[i] = $urandom;
        if ($urandom_range(0, 5) == 0) words[i] = HALT;
      end
      foreach (words[i]) begin
        if (!halted) begin
          exp_q.push_back(words[i]);
          if (words[i] == HALT || exp_q.size() == 32) halted = 1'b1;
        end
      end
      foreach (words[i]) send_word(words[i], 2);
      tick();
      tick();
      check("rnd_pulse_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check("rnd_word", got_q[i], exp_q[i]);
      check("rnd_count", {26'd0, O_WORD_COUNT}, exp_q.size());
      check("rnd_done", {31'd0, O_DONE}, {31'd0, halted});
      check("rnd_cpu_rst", {31'd0, O_CPU_RESET}, {31'd0, !halted});
    end

    // ---------------- 32 words without halt: overflow ----------------
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 32; i++) begin
      w = $urandom & 32'h7FFF_FFFF;
      send_word(w, 1);
    end
    wait_pulse(ok);
    tick();
    check("ovf_pulses", pulses - p0, 32'd32);
    check("ovf_count", {26'd0, O_WORD_COUNT}, 32'd32);
    check("ovf_flag", {31'd0, O_OVERFLOW}, 32'd1);
    check("ovf_done", {31'd0, O_DONE}, 32'd1);
    check("ovf_cpu_rst", {31'd0, O_CPU_RESET}, 32'd0);
    p0 = pulses;
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 1);
    tick();
    check("ovf_no_more_pulses", pulses - p0, 32'd0);
    check("ovf_sticky", {31'd0, O_OVERFLOW}, 32'd1);
    I_RELOAD = 1'b1;
    tick();
    I_RELOAD = 1'b0;
    check("ovf_reload_clear", {31'd0, O_OVERFLOW}, 32'd0);
    check("ovf_reload_count", {26'd0, O_WORD_COUNT}, 32'd0);
    check("ovf_reload_cpu_rst", {31'd0, O_CPU_RESET}, 32'd1);
    got_q.delete();
    send_word(32'h8765_4321, 2);
    wait_pulse(ok);
    check("ovf_resume_pulse", {31'd0, ok}, 32'd1);
    check("ovf_resume_data", O_WR_DATA_PM, 32'h8765_4321);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
